// File: rtl/ans_pkg.sv
// Shared definitions for the ANS frequency-table path: read types, arbiter
// states and default field widths.
package ans_pkg;

    localparam int CNT_WIDTH = 4;
    localparam int SYM_WIDTH = 4;

    localparam logic [1:0] READ_TYPE_NONE = 2'd0;
    localparam logic [1:0] READ_TYPE_PMF  = 2'd1;
    localparam logic [1:0] READ_TYPE_CMF  = 2'd2;
    localparam logic [1:0] READ_TYPE_ICMF = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ans_table_arbiter.sv
// Shares the single frequency-table read port between encoder (port 0) and
// decoder (port 1), with a response timeout. ANS_ARB_FIXED_PRIO_EN: decoder wins ties.
module ans_table_arbiter
    import ans_pkg::*;
#(
    parameter int CNT_WIDTH = ans_pkg::CNT_WIDTH,
    parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH,
    parameter int TIMEOUT   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [1:0]                     req0_type,
    input  logic [CNT_WIDTH+SYM_WIDTH-1:0] req0_query,
    output logic [CNT_WIDTH+SYM_WIDTH-1:0] req0_result,
    output logic                           req0_rdy,
    input  logic [1:0]                     req1_type,
    input  logic [CNT_WIDTH+SYM_WIDTH-1:0] req1_query,
    output logic [CNT_WIDTH+SYM_WIDTH-1:0] req1_result,
    output logic                           req1_rdy,
    output logic [1:0]                     tbl_type,
    output logic [CNT_WIDTH+SYM_WIDTH-1:0] tbl_query,
    input  logic [CNT_WIDTH+SYM_WIDTH-1:0] tbl_result,
    input  logic                           tbl_rdy,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int W  = CNT_WIDTH + SYM_WIDTH;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0][1:0]   req_type;
    logic [1:0][W-1:0] req_query;
    logic [1:0]        req_vld;
    logic              pick;

    arb_state_t        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        tbl_type_q, tbl_type_d;
    logic [W-1:0]      tbl_query_q, tbl_query_d;
    logic [1:0]        rdy_q, rdy_d;
    logic [1:0][W-1:0] result_q, result_d;
    logic              timeout_err_q, timeout_err_d;
    logic              busy_q, busy_d;
    logic              abandon_q, abandon_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_inc;
    logic              timed_out;

    assign req_type  = {req1_type, req0_type};
    assign req_query = {req1_query, req0_query};
    assign req_vld   = {req1_type != READ_TYPE_NONE, req0_type != READ_TYPE_NONE};

`ifdef ANS_ARB_FIXED_PRIO_EN
    assign pick = req_vld[1];
`else
    // On a tie the port that did not win last time goes next.
    assign pick = (req_vld == 2'b11) ? ~last_grant_q : req_vld[1];
`endif

    assign cnt_inc   = cnt_q + 1'b1;
    assign timed_out = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_grant_d  = last_grant_q;
        tbl_type_d    = tbl_type_q;
        tbl_query_d   = tbl_query_q;
        rdy_d         = rdy_q;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;
        abandon_d     = abandon_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!tbl_rdy && (req_vld != 2'b00)) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    tbl_type_d   = req_type[pick];
                    tbl_query_d  = req_query[pick];
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // A requester that changes its type or query has walked away.
                abandon_d = abandon_q
                          || (req_type[gnt_q] != tbl_type_q)
                          || (req_query[gnt_q] != tbl_query_q);
                if (tbl_rdy) begin
                    result_d[gnt_q] = tbl_result;
                    tbl_type_d      = READ_TYPE_NONE;
                    rdy_d[gnt_q]    = ~abandon_d;
                    state_d         = RESP;
                end else if (timed_out) begin
                    result_d[gnt_q] = '0;
                    tbl_type_d      = READ_TYPE_NONE;
                    timeout_err_d   = 1'b1;
                    rdy_d[gnt_q]    = ~abandon_d;
                    state_d         = RESP;
                end
            end
            RESP: begin
                rdy_d     = 2'b00;
                cnt_d     = '0;
                abandon_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            tbl_type_q    <= READ_TYPE_NONE;
            tbl_query_q   <= '0;
            rdy_q         <= 2'b00;
            result_q      <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            abandon_q     <= 1'b0;
            cnt_q         <= '0;
        end else if (ena) begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_grant_q  <= last_grant_d;
            tbl_type_q    <= tbl_type_d;
            tbl_query_q   <= tbl_query_d;
            rdy_q         <= rdy_d;
            result_q      <= result_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            abandon_q     <= abandon_d;
            cnt_q         <= cnt_d;
        end
    end

    assign tbl_type    = tbl_type_q;
    assign tbl_query   = tbl_query_q;
    assign req0_rdy    = rdy_q[0];
    assign req1_rdy    = rdy_q[1];
    assign req0_result = result_q[0];
    assign req1_result = result_q[1];
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/ans_table_arbiter.md
Name: ans_table_arbiter

Overview:
- Shares the single frequency-table read port (PMF/CMF/ICMF lookups) between two requesters: port 0 is the encoder and port 1 is the decoder.
- Each requester uses the existing table protocol: it holds a read type and query, receives a one-cycle ready pulse with the result, then drops its type to NONE.
- The arbiter issues one table transaction at a time, in round-robin order. It also applies a response timeout so a stalled table cannot hang either datapath.

Parameters:
- CNT_WIDTH, 4: count field width.
- SYM_WIDTH, 4: symbol width. Query/result width W = CNT_WIDTH+SYM_WIDTH.
- TIMEOUT, 16: maximum number of cycles spent waiting for tbl_rdy. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ena  in  1  clock enable; when low, all registers hold
- req0_type  in  2  encoder read type (NONE/PMF/CMF/ICMF)
- req0_query  in  W  encoder query
- req0_result  out  W  result to encoder
- req0_rdy  out  1  one-cycle result-valid pulse to encoder
- req1_type, req1_query, req1_result, req1_rdy: same as port 0, for the decoder
- tbl_type  out  2  read type to the table
- tbl_query  out  W  query to the table
- tbl_result  in  W  table result
- tbl_rdy  in  1  table result valid
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set on a timeout, cleared only by rst

Behaviour:
- One clock is used. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - tbl_type=NONE, tbl_query=0.
  - req0/1_rdy=0, req0/1_result=0.
  - busy=0, timeout_err=0.
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
- States are IDLE, WAIT and RESP.
- IDLE:
  - A port is requesting when reqN_type != NONE.
  - No issue while tbl_rdy=1.
  - If one port requests, grant it. If both request, grant the port != last_grant.
  - On grant: tbl_type/tbl_query <= granted type/query; last_grant <= grant; go to WAIT.
- WAIT:
  - tbl_type and tbl_query are held stable.
  - Each cycle, compare the granted port's live type/query with the latched values. Any difference marks the transaction abandoned.
  - On tbl_rdy=1: latch tbl_result into reqG_result and set tbl_type <= NONE.
  - If not abandoned, reqG_rdy <= 1. Go to RESP.
  - A wait counter increments each cycle. If TIMEOUT != 0 and the counter reaches TIMEOUT: reqG_result <= 0, tbl_type <= NONE, timeout_err <= 1, reqG_rdy <= 1 unless abandoned, go to RESP.
- RESP:
  - reqG_rdy is high for exactly this cycle. The requester drops its type at the end of this cycle.
  - The granted port is not re-sampled in this cycle.
  - Next edge: reqG_rdy <= 0, go to IDLE. The wait counter clears.
- The non-granted port's rdy stays 0 throughout. Its result register is unchanged.
- Latency, request first seen at IDLE edge E0:
  - tbl_type is valid after E0.
  - If tbl_rdy is high at the first WAIT edge E1, rdy is high during the E1–E2 cycle.
  - Minimum turnaround is 3 edges per transaction.
- Both ports request continuously: grants alternate 0,1,0,1.
- A new request arriving in RESP is served in the following IDLE. The requester sees rdy=0 before re-issuing.
- A request is never dropped. A port keeps its type held until it is served.
- rst asserted mid-transaction: everything returns to reset values in the next cycle and tbl_type=NONE immediately after. The table must tolerate a withdrawn query.
- ena=0 freezes state, outputs and the counter. Inputs are ignored.

Optional Feature:
- Macro: ANS_ARB_FIXED_PRIO_EN.
- Defined: port 1 (decoder) always wins ties. last_grant is unused and ties are not alternated.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Shared package ans_pkg holds:
  - READ_TYPE_NONE/PMF/CMF/ICMF (2-bit constants).
  - The arb_state_t enum: IDLE, WAIT, RESP.
  - Width constants CNT_WIDTH and SYM_WIDTH.
- No sub-module. The grant picker is a few lines of combinational logic inside the FSM.

Test Plan:
- Single request: port 1 issues CMF with query 15. Table returns 0x40 with tbl_rdy one cycle later. Expect req1_rdy pulsed for exactly 1 cycle, req1_result=0x40, tbl_type=NONE after, req0_rdy=0 throughout.
- Tie: both ports issue PMF from reset with queries 3 and 5. Expect tbl_query=3 first, then 5. Each rdy pulses once, in order.
- Contention: both ports hold requests for 6 transactions. Expect grants 0,1,0,1,0,1. With ANS_ARB_FIXED_PRIO_EN, expect all six to go to port 1 while port 1 keeps requesting.
- Timeout: port 0 issues ICMF and the table never asserts tbl_rdy, with TIMEOUT=16. After 16 WAIT cycles expect req0_rdy pulse, req0_result=0, timeout_err=1 (sticky), busy=0 after RESP.
- Abandon: port 1 drops to NONE mid-WAIT, then the table responds. Expect no req1_rdy, return to IDLE, next request served normally.
- Reset and ena: assert rst during WAIT and expect all outputs at reset values the next cycle. Drop ena for 5 cycles in WAIT and expect state, counter and outputs frozen.
